// File: rtl/sin_nco_if.sv
// Bundle of the NCO control inputs, LUT address/data pair and sample outputs.
// The slave side is the NCO itself; the master side is whoever drives the
// phase controls and owns the external quarter-wave LUT.
interface sin_nco_if #(
  parameter int ACC_W = 24
);
  logic              en;
  logic              sync;
  logic [ACC_W-1:0]  fcw;
  logic [7:0]        lut_addr;
  logic [7:0]        lut_data;
  logic signed [8:0] sample_out;
  logic              sample_valid;
  logic              wrap_pulse;

  modport master (
    output en, sync, fcw, lut_data,
    input  lut_addr, sample_out, sample_valid, wrap_pulse
  );

  modport slave (
    input  en, sync, fcw, lut_data,
    output lut_addr, sample_out, sample_valid, wrap_pulse
  );
endinterface

// File: rtl/sin_nco.sv
// Phase accumulator NCO front end: accumulates fcw into a phase register,
// folds the phase into quadrant + quarter-wave index for an external LUT,
// then mirrors/negates the LUT value into a full-period signed sample.
// Two-stage pipeline: stage A registers the LUT address, stage B registers
// the signed sample. sync clears the phase and drops in-flight samples.
module sin_nco #(
  parameter int ACC_W = 24
) (
  input  logic     clk,
  input  logic     rst_n,
  sin_nco_if.slave bus
);

  logic [ACC_W-1:0]  phase_acc_r;
  logic              wrap_pulse_r;
  logic [7:0]        lut_addr_r;
  logic              neg_a_r;
  logic              vld_a_r;
  logic signed [8:0] sample_out_r;
  logic              sample_valid_r;

  logic              advance_s;
  logic              emit_s;
  logic [ACC_W:0]    sum_s;
  logic [1:0]        quad_s;
  logic [7:0]        idx_s;
  logic [7:0]        addr_next_s;
  logic signed [8:0] sample_next_s;

  // Phase field decode, quarter-wave folding and sample sign application.
  always_comb begin
    advance_s     = bus.en & ~bus.sync;
    emit_s        = vld_a_r & ~bus.sync;
    sum_s         = {1'b0, phase_acc_r} + {1'b0, bus.fcw};
    quad_s        = phase_acc_r[ACC_W-1 -: 2];
    idx_s         = phase_acc_r[ACC_W-3 -: 8];
    addr_next_s   = idx_s;
    sample_next_s = $signed({1'b0, bus.lut_data});
    // Odd quadrants walk the quarter wave backwards.
    if (quad_s[0]) begin
      addr_next_s = ~idx_s;
    end else begin
      addr_next_s = idx_s;
    end
    // Negative half period; negating zero stays zero in 9 bits.
    if (neg_a_r) begin
      sample_next_s = 9'sd0 - $signed({1'b0, bus.lut_data});
    end else begin
      sample_next_s = $signed({1'b0, bus.lut_data});
    end
  end

  // Phase accumulator; the wrap flag is the carry of an accepted advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_acc_r  <= {ACC_W{1'b0}};
      wrap_pulse_r <= 1'b0;
    end else if (bus.sync) begin
      phase_acc_r  <= {ACC_W{1'b0}};
      wrap_pulse_r <= 1'b0;
    end else if (bus.en) begin
      phase_acc_r  <= sum_s[ACC_W-1:0];
      wrap_pulse_r <= sum_s[ACC_W];
    end else begin
      wrap_pulse_r <= 1'b0;
    end
  end

  // Stage A: LUT address and sign for the pre-increment phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lut_addr_r <= 8'd0;
      neg_a_r    <= 1'b0;
      vld_a_r    <= 1'b0;
    end else begin
      vld_a_r <= advance_s;
      if (advance_s) begin
        lut_addr_r <= addr_next_s;
        neg_a_r    <= quad_s[1];
      end
    end
  end

  // Stage B: signed sample from the LUT value; sync drops the in-flight one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_out_r   <= 9'sd0;
      sample_valid_r <= 1'b0;
    end else begin
      sample_valid_r <= emit_s;
      if (emit_s) begin
        sample_out_r <= sample_next_s;
      end
    end
  end

  assign bus.lut_addr     = lut_addr_r;
  assign bus.sample_out   = sample_out_r;
  assign bus.sample_valid = sample_valid_r;
  assign bus.wrap_pulse   = wrap_pulse_r;

endmodule
